fetch_pc_unit: RTL
==================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- ADDR_W, 9: instruction address width.
- DATA_W, 32: instruction width.
- STEP, 4: sequential PC increment.
- RESET_PC, 0: PC value at reset.
- DELAY_SLOT, 1: 1 = MIPS delayed branch; 0 = immediate redirect with one-bubble squash.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- Clk, input, 1: sole clock; all state updates on its rising edge.
- Reset, input, 1: synchronous, active-high reset.
- Stall, input, 1: hold PC, nPC and IF/ID contents.
- S, input, 1: take branch/jump to TA.
- TA, input, ADDR_W: target address.
- Flush, input, 1: clear IF/ID to NOP.
- IMemData, input, DATA_W: instruction read from asynchronous instruction ROM.
- IMemAddr, output, ADDR_W: combinational copy of PC.
- PC, output, ADDR_W: current fetch address.
- nPC, output, ADDR_W: next fetch address.
- IFID_Instr, output, DATA_W: latched instruction.
- IFID_PC, output, ADDR_W: PC of the latched instruction.
- IFID_Valid, output, 1: latched instruction is live, not a bubble.
- IFID_DelaySlot, output, 1: latched instruction is a branch delay slot.

REQ-003 Clk and Reset SHALL be the only clock and reset; Reset SHALL be synchronous and active-high.

Function
REQ-004 All address arithmetic SHALL be modulo 2^ADDR_W; (2^ADDR_W - STEP) + STEP SHALL wrap to 0.
REQ-005 The block SHALL implement a 2-state FSM, SEQ and DSLOT, that is used only when DELAY_SLOT=1 (it remains in SEQ when DELAY_SLOT=0).
REQ-006 When the block is not stalled and S=0, it SHALL perform: PC<=nPC, nPC<=nPC+STEP, IFID_Instr<=IMemData, IFID_PC<=PC, IFID_Valid<=1.
REQ-007 When DELAY_SLOT=1, not stalled, and S=1, the block SHALL perform: PC<=nPC (delay slot), nPC<=TA, IF/ID loads normally, and FSM->DSLOT.
REQ-008 In DSLOT, the next non-stalled edge SHALL load IF/ID with IFID_DelaySlot=1 and return the FSM to SEQ.
- An S=1 on that edge SHALL be honoured per REQ-007, and the FSM SHALL stay in DSLOT.
REQ-009 When DELAY_SLOT=0, not stalled, and S=1, the block SHALL perform: PC<=TA, nPC<=TA+STEP, IFID_Instr<=0, IFID_Valid<=0 (wrong-path fetch squashed).
REQ-010 When Stall=1, PC, nPC, the FSM state and IF/ID SHALL hold; S and TA SHALL be ignored, and the ID stage re-presents them.
REQ-011 Flush=1 SHALL force IFID_Instr=0, IFID_Valid=0 and IFID_DelaySlot=0 on that edge.
- Flush SHALL take effect even when Stall=1.
- Flush SHALL NOT affect PC, nPC or the FSM.
REQ-012 Priority SHALL be Reset > Flush (IF/ID only) > Stall > S > sequential.
REQ-013 IFID_DelaySlot SHALL be 0 whenever DELAY_SLOT=0 or IFID_Valid=0.
REQ-014 TA SHALL be used unmodified, with no alignment correction.
REQ-015 Fetch latency SHALL be one cycle: the instruction at address A SHALL appear on IFID_Instr on the edge after PC=A, if that edge is unstalled.

Reset
REQ-016 While Reset=1 at an edge, the block SHALL load:
- PC = RESET_PC
- nPC = RESET_PC+STEP
- IFID_Instr = 0
- IFID_PC = 0
- IFID_Valid = 0
- IFID_DelaySlot = 0
- FSM = SEQ
REQ-017 Reset SHALL override any in-flight branch, stall or flush, including a pending DSLOT.
REQ-018 Output values before the first reset edge SHALL be unspecified.

Structure
REQ-019 The FSM state encoding and the NOP constant (all zeros) SHALL reside in a shared package, pipeline_pkg.
REQ-020 The IF/ID register SHALL be a sub-module, ifid_reg, with hold, clear and load controls.
REQ-021 The PC/nPC update logic SHALL remain in fetch_pc_unit.
REQ-022 The implementation SHALL use no latches and no asynchronous reset.

Verification
REQ-023 Reset then run 4 unstalled cycles:
- PC SHALL be 0, 4, 8, 12, 16.
- IFID_PC SHALL be 0, 4, 8, 12, each with IFID_Valid=1.
REQ-024 DELAY_SLOT=1, S=1 with TA=100 while PC=8 and nPC=12:
- Next edge: PC=12, nPC=100.
- Edge after: PC=100 and IFID_PC=12 with IFID_DelaySlot=1.
REQ-025 DELAY_SLOT=0, S=1 with TA=100 while PC=8:
- Next edge: PC=100, nPC=104, IFID_Valid=0, IFID_Instr=0.
REQ-026 Stall=1 for 3 cycles with S=1 and Flush=1 on the middle cycle:
- PC and nPC SHALL be unchanged throughout.
- IF/ID SHALL be cleared only at the middle edge.
- The branch SHALL be taken on the first unstalled edge.
REQ-027 ADDR_W=9, nPC=508, sequential edge: PC=508, nPC=0 (wrap).
REQ-028 Reset=1 asserted while in DSLOT: all outputs SHALL equal the REQ-016 values and FSM=SEQ on that edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the fetch stage:
//   - fetch_state_e : the two states of the delayed-branch sequencer
//   - NOP_BIT       : fill bit for the no-op instruction word, which is all zeros.
//                     It is replicated to the instruction width at the point of use.
package pipeline_pkg;

  // SEQ   : ordinary sequential fetch.
  // DSLOT : the next instruction to be latched is a branch delay slot.
  typedef enum logic [0:0] {
    SEQ   = 1'b0,
    DSLOT = 1'b1
  } fetch_state_e;

  // A bubble in IF/ID carries an all-zero instruction word.
  localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg
// IF/ID pipeline register.
// Priority: reset > clear > hold > load.
//
// Ports:
//   clk           : clock, rising edge
//   reset         : synchronous active-high reset; empties the register
//   hold          : keep the current contents
//   clear         : replace the contents with a NOP bubble; this beats hold
//   load          : capture a live instruction
//   instr_in      : instruction word to capture
//   pc_in         : fetch address of instr_in
//   delay_slot_in : instr_in occupies a branch delay slot
//   instr         : latched instruction
//   pc            : latched fetch address
//   valid         : the latched entry is live (1) or a bubble (0)
//   delay_slot    : the latched entry is a delay slot instruction
module ifid_reg
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              delay_slot_in,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              valid,
  output logic              delay_slot
);

  // Reset and clear both leave a bubble.
  // A bubble never carries a stale delay-slot flag.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      instr      <= {DATA_W{NOP_BIT}};
      pc         <= '0;
      valid      <= 1'b0;
      delay_slot <= 1'b0;
    end else if (!hold && load) begin
      instr      <= instr_in;
      pc         <= pc_in;
      valid      <= 1'b1;
      delay_slot <= delay_slot_in;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Instruction fetch stage: PC/nPC sequencing, branch redirection and the IF/ID register.
//
// Parameters:
//   ADDR_W     : instruction address width
//   DATA_W     : instruction width
//   STEP       : sequential PC increment
//   RESET_PC   : PC value loaded at reset
//   DELAY_SLOT : 1 = delayed branch; 0 = immediate redirect that squashes the wrong-path fetch
//
// Ports:
//   Clk            : clock, rising edge
//   Reset          : synchronous active-high reset
//   Stall          : hold PC, nPC, the FSM and IF/ID
//   S              : take the branch or jump to TA
//   TA             : target address, used exactly as given
//   Flush          : clear IF/ID to a bubble; takes effect even while stalled
//   IMemData       : instruction from the asynchronous ROM at IMemAddr
//   IMemAddr       : ROM address, which is the current PC
//   PC, nPC        : current and next fetch address
//   IFID_Instr     : latched instruction
//   IFID_PC        : fetch address of the latched instruction
//   IFID_Valid     : the latched instruction is live
//   IFID_DelaySlot : the latched instruction is a delay slot
module fetch_pc_unit
  import pipeline_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STEP       = 4,
  parameter int RESET_PC   = 0,
  parameter int DELAY_SLOT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              S,
  input  logic [ADDR_W-1:0] TA,
  input  logic              Flush,
  input  logic [DATA_W-1:0] IMemData,
  output logic [ADDR_W-1:0] IMemAddr,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] nPC,
  output logic [DATA_W-1:0] IFID_Instr,
  output logic [ADDR_W-1:0] IFID_PC,
  output logic              IFID_Valid,
  output logic              IFID_DelaySlot
);

  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc_q;
  fetch_state_e      state_q;

  logic squash;
  logic ifid_clear;
  logic in_dslot;

  // Without delay slots, a taken branch turns the instruction fetched
  // this cycle into wrong-path work, so it enters IF/ID as a bubble.
  assign squash     = (DELAY_SLOT == 0) && S && !Stall;
  assign ifid_clear = Flush || squash;
  assign in_dslot   = (DELAY_SLOT != 0) && (state_q == DSLOT);

  // PC/nPC sequencing and the delayed-branch FSM.
  // With delay slots, a taken branch still fetches from nPC (the slot) and
  // queues TA behind it. A branch that sits in a delay slot keeps the FSM in
  // DSLOT, so the following instruction is also marked as a slot.
  // Address sums keep only ADDR_W bits, so the top of the space wraps to 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= RESET_A;
      npc_q   <= RESET_A + STEP_A;
      state_q <= SEQ;
    end else if (!Stall) begin
      if (S && (DELAY_SLOT != 0)) begin
        pc_q    <= npc_q;
        npc_q   <= TA;
        state_q <= DSLOT;
      end else if (S) begin
        pc_q    <= TA;
        npc_q   <= TA + STEP_A;
        state_q <= SEQ;
      end else begin
        pc_q    <= npc_q;
        npc_q   <= npc_q + STEP_A;
        state_q <= SEQ;
      end
    end
  end

  ifid_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ifid (
    .clk          (Clk),
    .reset        (Reset),
    .hold         (Stall),
    .clear        (ifid_clear),
    .load         (!Stall),
    .instr_in     (IMemData),
    .pc_in        (pc_q),
    .delay_slot_in(in_dslot),
    .instr        (IFID_Instr),
    .pc           (IFID_PC),
    .valid        (IFID_Valid),
    .delay_slot   (IFID_DelaySlot)
  );

  assign PC       = pc_q;
  assign nPC      = npc_q;
  assign IMemAddr = pc_q;

endmodule
